// File: rtl/spi_pkt_pkg.sv
// Shared packet constants, FSM state type and packet-length helper for the SPI sensor slave.
// Build option: SPI_PKT_CHECKSUM_EN appends an XOR checksum byte to every packet.
`timescale 1ns/1ps
package spi_pkt_pkg;
  localparam logic [7:0] HEADER_DEFAULT   = 8'hAA;
  localparam int         BYTES_PER_SENSOR = 15;
  localparam int         MAX_SENSORS      = 4;

`ifdef SPI_PKT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_WAIT_HI,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_TRAIL
  } state_t;

  function automatic int pkt_len(input int n);
    return 2 + BYTES_PER_SENSOR * n + (CSUM_EN ? 1 : 0);
  endfunction

  localparam int MAX_PKT_LEN = pkt_len(MAX_SENSORS);
  localparam int BCNT_W      = $clog2(MAX_PKT_LEN + 1);
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with single-cycle rise/fall pulses
// derived from the synchronized samples. Resets to 0 so a low input never looks like a fall.
`timescale 1ns/1ps
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_sensor_slave_multi.sv
// Read-only SPI mode-0 slave streaming a snapshot of up to four quaternion/gyro sensors.
// Build option: SPI_PKT_CHECKSUM_EN appends the XOR of all preceding bytes as a final byte.
`timescale 1ns/1ps
module spi_sensor_slave_multi
  import spi_pkt_pkg::*;
#(
  parameter int         NUM_SENSORS = 1,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs_n,
  input  logic                      sck,
  input  logic                      sdi,
  output logic                      sdo,
  input  logic [NUM_SENSORS-1:0]    quat_valid,
  input  logic [NUM_SENSORS*64-1:0] quat,
  input  logic [NUM_SENSORS-1:0]    gyro_valid,
  input  logic [NUM_SENSORS*48-1:0] gyro,
  output logic                      pkt_done,
  output logic                      short_read,
  output logic [7:0]                seq
);
  localparam int                PKT_LEN   = pkt_len(NUM_SENSORS);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PKT_LEN - 1);

  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic w_sdi_unused;

  state_t                   r_state;
  logic [7:0]               r_shreg;
  logic [2:0]               r_bit_cnt;
  logic [BCNT_W-1:0]        r_byte_cnt;
  logic [7:0]               r_seq;
  logic [7:0]               r_csum;
  logic [1:0]               r_age;
  logic                     r_seen_rise;
  logic                     r_pkt_done;
  logic                     r_short_read;
  logic [NUM_SENSORS*64-1:0] r_snap_quat;
  logic [NUM_SENSORS*48-1:0] r_snap_gyro;
  logic [NUM_SENSORS-1:0]    r_snap_qv;
  logic [NUM_SENSORS-1:0]    r_snap_gv;
  logic [7:0]               r_snap_seq;

  logic [BCNT_W-1:0] w_next_idx;
  logic [7:0]        w_next_byte;

  assign w_sdi_unused = sdi;

  spi_sync_edge u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(cs_n),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(sck),
    .o_sync (w_sck_level_unused),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  // Byte that follows the one currently in the shift register, taken from the frozen snapshot.
  always_comb begin
    w_next_idx  = r_byte_cnt + BCNT_W'(1);
    w_next_byte = 8'h00;
    if (w_next_idx == BCNT_W'(1))
      w_next_byte = r_snap_seq;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      for (int o = 0; o < 8; o++)
        if (w_next_idx == BCNT_W'(2 + BYTES_PER_SENSOR * k + o))
          w_next_byte = r_snap_quat[k*64 + 63 - 8*o -: 8];
      for (int g = 0; g < 6; g++)
        if (w_next_idx == BCNT_W'(2 + BYTES_PER_SENSOR * k + 8 + g))
          w_next_byte = r_snap_gyro[k*48 + 47 - 8*g -: 8];
      if (w_next_idx == BCNT_W'(2 + BYTES_PER_SENSOR * k + 14))
        w_next_byte = {6'b0, r_snap_gv[k], r_snap_qv[k]};
    end
    if (CSUM_EN && (w_next_idx == LAST_BYTE))
      w_next_byte = r_csum;
  end

  // A cs_n rise seen fewer than two cycles after the fall is a glitch, not an aborted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_WAIT_HI;
      r_shreg      <= HEADER;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_seq        <= '0;
      r_csum       <= '0;
      r_age        <= '0;
      r_seen_rise  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_short_read <= 1'b0;
      r_snap_quat  <= '0;
      r_snap_gyro  <= '0;
      r_snap_qv    <= '0;
      r_snap_gv    <= '0;
      r_snap_seq   <= '0;
    end else begin
      r_pkt_done   <= 1'b0;
      r_short_read <= 1'b0;
      case (r_state)
        ST_WAIT_HI: begin
          if (w_cs_sync)
            r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_snap_quat <= quat;
            r_snap_gyro <= gyro;
            r_snap_qv   <= quat_valid;
            r_snap_gv   <= gyro_valid;
            r_snap_seq  <= r_seq;
            r_age       <= '0;
            r_seen_rise <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_cs_rise) begin
            r_state <= ST_IDLE;
          end else begin
            r_shreg    <= HEADER;
            r_csum     <= HEADER;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_age      <= r_age + 2'd1;
            if (w_sck_rise)
              r_seen_rise <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            if (r_age == 2'd2)
              r_short_read <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            if (r_age != 2'd2)
              r_age <= r_age + 2'd1;
            if (w_sck_rise)
              r_seen_rise <= 1'b1;
            if (w_sck_fall && r_seen_rise) begin
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= '0;
                if (r_byte_cnt == LAST_BYTE) begin
                  r_shreg <= 8'h00;
                  r_state <= ST_TRAIL;
                end else begin
                  r_shreg    <= w_next_byte;
                  r_csum     <= r_csum ^ w_next_byte;
                  r_byte_cnt <= w_next_idx;
                end
              end else begin
                r_shreg   <= {r_shreg[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
        end
        ST_TRAIL: begin
          if (w_cs_rise) begin
            r_pkt_done <= 1'b1;
            r_seq      <= r_seq + 8'd1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_WAIT_HI;
      endcase
    end
  end

  assign sdo        = cs_n ? 1'bz : r_shreg[7];
  assign pkt_done   = r_pkt_done;
  assign short_read = r_short_read;
  assign seq        = r_seq;
endmodule

// File: tb/tb_spi_sensor_slave_multi.sv
// Bench for spi_sensor_slave_multi: one-sensor and two-sensor instances share the SPI bus
// and are compared byte-by-byte against a packet model built from the sensor values.
`timescale 1ns/1ps
module tb_spi_sensor_slave_multi;
`ifdef SPI_PKT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int PL1 = 17 + CK;
  localparam int PL2 = 32 + CK;

  logic clk = 1'b0;
  logic rst, cs_n, sck, sdi;
  always #5 clk = ~clk;

  logic [15:0]  s_q [2][4];
  logic [15:0]  s_g [2][3];
  logic [1:0]   s_qv, s_gv;
  logic [63:0]  quat1;
  logic [127:0] quat2;
  logic [47:0]  gyro1;
  logic [95:0]  gyro2;

  always_comb begin
    quat1 = {s_q[0][0], s_q[0][1], s_q[0][2], s_q[0][3]};
    quat2 = {s_q[1][0], s_q[1][1], s_q[1][2], s_q[1][3], quat1};
    gyro1 = {s_g[0][0], s_g[0][1], s_g[0][2]};
    gyro2 = {s_g[1][0], s_g[1][1], s_g[1][2], gyro1};
  end

  wire       sdo1, sdo2, pd1, pd2, sr1, sr2;
  wire [7:0] seq1, seq2;

  spi_sensor_slave_multi #(.NUM_SENSORS(1), .HEADER(8'hAA)) dut1 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .sdi(sdi), .sdo(sdo1),
    .quat_valid(s_qv[0:0]), .quat(quat1), .gyro_valid(s_gv[0:0]), .gyro(gyro1),
    .pkt_done(pd1), .short_read(sr1), .seq(seq1));

  spi_sensor_slave_multi #(.NUM_SENSORS(2), .HEADER(8'hAA)) dut2 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .sdi(sdi), .sdo(sdo2),
    .quat_valid(s_qv), .quat(quat2), .gyro_valid(s_gv), .gyro(gyro2),
    .pkt_done(pd2), .short_read(sr2), .seq(seq2));

  int n_chk = 0, n_pass = 0;
  int n_done1 = 0, n_done2 = 0, n_sr1 = 0, n_sr2 = 0;
  logic [7:0] eseq1 = 8'd0, eseq2 = 8'd0;
  logic [7:0] rx1 [64];
  logic [7:0] rx2 [64];

  always @(negedge clk) begin
    if (pd1 === 1'b1) n_done1++;
    if (pd2 === 1'b1) n_done2++;
    if (sr1 === 1'b1) n_sr1++;
    if (sr2 === 1'b1) n_sr2++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required summary before 900us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) s_q[k][c] = 16'($urandom);
      for (int c = 0; c < 3; c++) s_g[k][c] = 16'($urandom);
    end
    s_qv = 2'($urandom);
    s_gv = 2'($urandom);
    sdi  = 1'($urandom);
  endtask

  // Packet as the MCU should see it; bytes past the packet are zero.
  task automatic build_exp(input int n, input logic [7:0] sq, output logic [7:0] e [64]);
    int p;
    logic [7:0] x;
    for (int i = 0; i < 64; i++) e[i] = 8'h00;
    e[0] = 8'hAA;
    e[1] = sq;
    p = 2;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) begin
        e[p] = s_q[k][c][15:8]; e[p+1] = s_q[k][c][7:0]; p = p + 2;
      end
      for (int c = 0; c < 3; c++) begin
        e[p] = s_g[k][c][15:8]; e[p+1] = s_g[k][c][7:0]; p = p + 2;
      end
      e[p] = {6'b0, s_gv[k], s_qv[k]};
      p = p + 1;
    end
    if (CK == 1) begin
      x = 8'h00;
      for (int i = 0; i < p; i++) x = x ^ e[i];
      e[p] = x;
    end
  endtask

  task automatic spi_read(input int nbytes, input int change_at, input bit keep_cs);
    cs_n = 1'b0;
    #80;
    for (int b = 0; b < nbytes; b++) begin
      if (b == change_at) rand_inputs();
      for (int i = 7; i >= 0; i--) begin
        if (b < 64) begin
          rx1[b][i] = sdo1;
          rx2[b][i] = sdo2;
        end
        sck = 1'b1; #40;
        sck = 1'b0; #40;
      end
    end
    if (!keep_cs) begin
      cs_n = 1'b1;
      #80;
    end
  endtask

  task automatic run_txn(input int nbytes, input int change_at, input bit ed1, input bit ed2);
    logic [7:0] e1 [64];
    logic [7:0] e2 [64];
    int bd1, bd2, bs1, bs2;
    build_exp(1, eseq1, e1);
    build_exp(2, eseq2, e2);
    bd1 = n_done1; bd2 = n_done2; bs1 = n_sr1; bs2 = n_sr2;
    spi_read(nbytes, change_at, 1'b0);
    for (int i = 0; i < nbytes && i < 64; i++) begin
      chk($sformatf("n1_byte[%0d]", i), 32'(rx1[i]), 32'(e1[i]));
      chk($sformatf("n2_byte[%0d]", i), 32'(rx2[i]), 32'(e2[i]));
    end
    chk("n1_pkt_done", 32'(n_done1 - bd1), 32'(ed1));
    chk("n2_pkt_done", 32'(n_done2 - bd2), 32'(ed2));
    chk("n1_short_read", 32'(n_sr1 - bs1), 32'(!ed1));
    chk("n2_short_read", 32'(n_sr2 - bs2), 32'(!ed2));
    if (ed1) eseq1 = eseq1 + 8'd1;
    if (ed2) eseq2 = eseq2 + 8'd1;
    chk("n1_seq", 32'(seq1), 32'(eseq1));
    chk("n2_seq", 32'(seq2), 32'(eseq2));
  endtask

  typedef struct {
    int nbytes;
    int change_at;
    bit exp_done1;
    bit exp_done2;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] gold [18];

  initial begin
    int bd1, bd2, bs1, bs2, hi1, hi2, nb;

    vecs[0] = '{PL2,     -1, 1'b1, 1'b1};
    vecs[1] = '{PL1,     -1, 1'b1, 1'b0};
    vecs[2] = '{5,       -1, 1'b0, 1'b0};
    vecs[3] = '{PL1,     -1, 1'b1, 1'b0};
    vecs[4] = '{PL2 + 8, 10, 1'b1, 1'b1};
    vecs[5] = '{1,       -1, 1'b0, 1'b0};
    vecs[6] = '{40,       3, 1'b1, 1'b1};
    vecs[7] = '{PL2 - 1, -1, 1'b1, 1'b0};
    vecs[8] = '{PL1 - 1, -1, 1'b0, 1'b0};

    gold = '{8'hAA, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
             8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h03, 8'hA9};

    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) s_q[k][c] = 16'h0;
      for (int c = 0; c < 3; c++) s_g[k][c] = 16'h0;
    end
    s_qv = 2'b00; s_gv = 2'b00;
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
    #23;
    chk("reset_seq1", 32'(seq1), 32'd0);
    chk("reset_seq2", 32'(seq2), 32'd0);
    chk("reset_pulses", 32'({pd1, pd2, sr1, sr2}), 32'd0);
    rst = 1'b0;
    #100;

    // Known single-sensor packet
    s_q[0][0] = 16'd1; s_q[0][1] = 16'd2; s_q[0][2] = 16'd3; s_q[0][3] = 16'd4;
    s_g[0][0] = 16'd5; s_g[0][1] = 16'd6; s_g[0][2] = 16'd7;
    s_qv = 2'b11; s_gv = 2'b11;
    run_txn(PL1, -1, 1'b1, 1'b0);
    for (int i = 0; i < PL1; i++)
      chk($sformatf("known_byte[%0d]", i), 32'(rx1[i]), 32'(gold[i]));
    chk("known_seq_after", 32'(seq1), 32'd1);

    for (int v = 0; v < 9; v++) begin
      rand_inputs();
      run_txn(vecs[v].nbytes, vecs[v].change_at, vecs[v].exp_done1, vecs[v].exp_done2);
    end

    // cs_n glitches of one and two clocks must not start a transaction
    for (int w = 1; w <= 2; w++) begin
      bd1 = n_done1; bd2 = n_done2; bs1 = n_sr1; bs2 = n_sr2;
      cs_n = 1'b0;
      #(10 * w);
      cs_n = 1'b1;
      #100;
      chk($sformatf("glitch%0d_pulses", w), 32'((n_done1 - bd1) + (n_done2 - bd2) + (n_sr1 - bs1) + (n_sr2 - bs2)), 32'd0);
      chk($sformatf("glitch%0d_seq1", w), 32'(seq1), 32'(eseq1));
    end
    rand_inputs();
    run_txn(PL1, -1, 1'b1, 1'b0);

    // Reset in the middle of a packet, released while cs_n is still low
    rand_inputs();
    spi_read(3, -1, 1'b1);
    rst = 1'b1;
    #20;
    chk("midrst_sdo1", 32'(sdo1), 32'd1);
    chk("midrst_seq2", 32'(seq2), 32'd0);
    rst = 1'b0;
    eseq1 = 8'd0; eseq2 = 8'd0;
    bd1 = n_done1; bd2 = n_done2; bs1 = n_sr1; bs2 = n_sr2;
    #80;
    hi1 = 0; hi2 = 0;
    for (int i = 0; i < 16; i++) begin
      if (sdo1 === 1'b1) hi1++;
      if (sdo2 === 1'b1) hi2++;
      sck = 1'b1; #40;
      sck = 1'b0; #40;
    end
    chk("postrst_sdo1_high", 32'(hi1), 32'd16);
    chk("postrst_sdo2_high", 32'(hi2), 32'd16);
    cs_n = 1'b1;
    #80;
    chk("postrst_pulses", 32'((n_done1 - bd1) + (n_done2 - bd2) + (n_sr1 - bs1) + (n_sr2 - bs2)), 32'd0);
    run_txn(PL2, -1, 1'b1, 1'b1);

    for (int r = 0; r < 12; r++) begin
      rand_inputs();
      nb = $urandom_range(40, 1);
      run_txn(nb, $urandom_range(nb, 0), nb >= PL1, nb >= PL2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_sensor_slave_multi.md
SPI_SENSOR_SLAVE_MULTI -- requirements
Module: spi_sensor_slave_multi

Interface
REQ-001 Parameter NUM_SENSORS, default 1, number of sensor blocks in the packet (legal range 1..4).
REQ-002 Parameter HEADER, default 8'hAA, first packet byte.
REQ-003 Port clk  input  1  FPGA system clock, at least 8x SCK frequency.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port cs_n  input  1  MCU chip select, active low, asynchronous to clk.
REQ-006 Port sck  input  1  MCU SPI clock, SPI mode 0, asynchronous to clk.
REQ-007 Port sdi  input  1  MOSI; ignored (read-only).
REQ-008 Port sdo  output  1  MISO; high-Z while cs_n high, else shift-register MSB.
REQ-009 Port quat_valid  input  NUM_SENSORS  per-sensor quaternion valid.
REQ-010 Port quat  input  NUM_SENSORS*64  per sensor {w,x,y,z} signed 16-bit; sensor 0 in the LSBs.
REQ-011 Port gyro_valid  input  NUM_SENSORS  per-sensor gyro valid.
REQ-012 Port gyro  input  NUM_SENSORS*48  per sensor {x,y,z} signed 16-bit; sensor 0 in the LSBs.
REQ-013 Port pkt_done  output  1  one-clk pulse when cs_n rises after all packet bytes have shifted out.
REQ-014 Port short_read  output  1  one-clk pulse when cs_n rises before the packet is complete.
REQ-015 Port seq  output  8  sequence number of the next packet.

Function
REQ-016 All logic is clocked on clk; cs_n and sck pass through 2-flop synchronizers; SCK edges are detected from synchronized samples.
REQ-017 Packet layout: HEADER, seq, then per sensor k=0..N-1 {w,x,y,z MSB/LSB (8 B), gyro x,y,z MSB/LSB (6 B), flags {6'b0,gyro_valid,quat_valid}}, then optional checksum (REQ-030); PKT_LEN = 2+15*N (+1).
REQ-018 On a synchronized cs_n fall, all sensor inputs and seq are snapshotted in that cycle; the snapshot is frozen until cs_n rises.
REQ-019 The shift register loads HEADER on the clk after the snapshot, so sdo MSB is valid at most 4 clk after the raw cs_n fall.
REQ-020 Data is shifted MSB-first on each detected SCK falling edge; the first falling edge after the first rising edge of a transaction shifts to bit 6.
REQ-021 After the 8th bit of byte i, byte i+1 loads on the same falling edge with no bubble.
REQ-022 Once PKT_LEN bytes have been sent, the FSM enters TRAIL and sdo outputs 0; further SCK edges do not wrap.
REQ-023 FSM: WAIT_HI -> IDLE (cs_n sync high); IDLE -> LOAD (cs_n fall); LOAD -> SHIFT (1 clk); SHIFT -> TRAIL (last bit of the last byte); SHIFT/TRAIL -> IDLE (cs_n rise).
REQ-024 On cs_n rise from TRAIL: pkt_done pulses and seq increments modulo 256 (255 -> 0). On cs_n rise from LOAD/SHIFT: short_read pulses and seq is unchanged.
REQ-025 If cs_n falls and rises within 2 clk (glitch), no transaction starts and neither pulse fires.
REQ-026 Input changes during a transaction do not affect the bytes sent.

Reset
REQ-027 While rst is high: state = WAIT_HI, shift register = HEADER, byte/bit counters = 0, seq = 0, pkt_done = 0, short_read = 0, snapshot = 0.
REQ-028 After rst releases with cs_n already low, the block stays in WAIT_HI and does not drive a packet until cs_n has been seen high.
REQ-029 sdo follows REQ-008 during reset.

Configuration
REQ-030 With SPI_PKT_CHECKSUM_EN defined, a final byte equal to the XOR of all preceding packet bytes is appended (PKT_LEN = 3+15*N). Without the macro, no checksum byte is sent (PKT_LEN = 2+15*N).

Structure
REQ-031 Package spi_pkt_pkg holds HEADER_DEFAULT, BYTES_PER_SENSOR=15, the state enum, and a pkt_len(N) function.
REQ-032 Sub-module spi_sync_edge (2-flop synchronizer with rise/fall pulses) is used for cs_n and sck.
REQ-033 Byte counter width is $clog2(max PKT_LEN + 1).

Verification
REQ-034 N=1, quat={1,2,3,4}, gyro={5,6,7}, both valid, full read -> AA 00 00 01 00 02 00 03 00 04 00 05 00 06 00 07 03 [checksum], pkt_done=1, seq=1.
REQ-035 N=2, read 40 bytes -> bytes after PKT_LEN are 00 and pkt_done pulses once.
REQ-036 Abort after 5 bytes -> short_read pulse, seq unchanged; next read header AA with the same seq.
REQ-037 Change quat mid-transaction -> sent bytes match the values at cs_n fall.
REQ-038 Assert rst mid-packet, release with cs_n low -> sdo stays HEADER MSB, no pulses until a cs_n high-low cycle.
REQ-039 256 full reads -> seq wraps 255 -> 0; checksum matches per read when SPI_PKT_CHECKSUM_EN is defined.
